// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory block-copy engine.
package mem_copy_pkg;

  localparam int unsigned AwDefault = 8;
  localparam int unsigned DwDefault = 8;
  localparam int unsigned LwDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } copy_state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus-master block-copy engine: ascending byte copy inside the data memory.
// Optional constant-fill mode is enabled by defining MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault,
  parameter int unsigned LW = LwDefault
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [LW-1:0] Len,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] MemAddress,
  output logic          MemWriteEn,
  output logic [DW-1:0] MemDataOut,
`ifdef MEM_COPY_FILL_EN
  input  logic          FillEn,
  input  logic [DW-1:0] FillData,
`endif
  input  logic [DW-1:0] MemDataIn
);

  copy_state_e   state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          fill_q, fill_d;
  logic [DW-1:0] fill_data_q, fill_data_d;
  logic          start_fill;
  logic [DW-1:0] start_fill_data;

`ifdef MEM_COPY_FILL_EN
  assign start_fill      = FillEn;
  assign start_fill_data = FillData;
`else
  assign start_fill      = 1'b0;
  assign start_fill_data = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      buf_q       <= '0;
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
    Busy        = 1'b1;
    Done        = 1'b0;
    MemAddress  = '0;
    MemWriteEn  = 1'b0;
    MemDataOut  = '0;

    unique case (state_q)
      StIdle: begin
        Busy = 1'b0;
        if (Start) begin
          src_d       = SrcAddr;
          dst_d       = DstAddr;
          rem_d       = Len;
          fill_d      = start_fill;
          fill_data_d = start_fill_data;
          if (Len == '0) begin
            state_d = StDone;
          end else if (start_fill) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        MemAddress = src_q;
        buf_d      = MemDataIn;
        state_d    = StWrite;
      end
      StWrite: begin
        MemAddress = dst_q;
        MemWriteEn = 1'b1;
        MemDataOut = fill_q ? fill_data_q : buf_q;
        // Pointers wrap modulo 2^AW by plain truncation.
        src_d      = src_q + AW'(1);
        dst_d      = dst_q + AW'(1);
        rem_d      = rem_q - LW'(1);
        if (rem_q == LW'(1)) begin
          state_d = StDone;
        end else if (fill_q) begin
          state_d = StWrite;
        end else begin
          state_d = StRead;
        end
      end
      StDone: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: memory model plus write scoreboard.
module tb_mem_copy_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic       Busy, Done, MemWriteEn;
  logic [7:0] MemAddress, MemDataOut, MemDataIn;
`ifdef MEM_COPY_FILL_EN
  logic       FillEn;
  logic [7:0] FillData;
`endif

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  mem_copy_engine #(.AW(8), .DW(8), .LW(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .Busy       (Busy),
    .Done       (Done),
    .MemAddress (MemAddress),
    .MemWriteEn (MemWriteEn),
    .MemDataOut (MemDataOut),
`ifdef MEM_COPY_FILL_EN
    .FillEn     (FillEn),
    .FillData   (FillData),
`endif
    .MemDataIn  (MemDataIn)
  );

  always #5 Clk = ~Clk;

  assign MemDataIn = mem[MemAddress];

  always @(posedge Clk) begin
    if (MemWriteEn) mem[MemAddress] = MemDataOut;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and score any write strobe seen there.
  task automatic step();
    wr_t e;
    @(negedge Clk);
    if (MemWriteEn === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'(MemAddress), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("write_addr", 32'(MemAddress), 32'(e.addr));
        check_eq("write_data", 32'(MemDataOut), 32'(e.data));
      end
    end
  endtask

  // Reference copy: strictly ascending, byte at a time, so overlap propagates.
  task automatic push_copy(input logic [7:0] src, input logic [7:0] dst, input int len);
    logic [7:0] m [256];
    logic [7:0] s, d;
    wr_t e;
    for (int i = 0; i < 256; i++) m[i] = mem[i];
    for (int i = 0; i < len; i++) begin
      s = src + 8'(i);
      d = dst + 8'(i);
      m[d] = m[s];
      e.addr = d;
      e.data = m[s];
      exp_q.push_back(e);
    end
  endtask

  task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                          input int exp_done, input int exp_wr, input bit repulse);
    int done_cyc = -1;
    int busy_cyc = 0;
    n_writes = 0;
    SrcAddr = src;
    DstAddr = dst;
    Len     = len;
    Start   = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (c == 1) Start = 1'b0;
      if (Busy === 1'b1) busy_cyc++;
      if (repulse && c == 3) begin
        Start   = 1'b1;
        SrcAddr = 8'hF0;
        DstAddr = 8'hF8;
        Len     = 8'd9;
      end
      if (repulse && c == 4) Start = 1'b0;
      if (Done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    // Start coinciding with DONE must not be accepted.
    if (repulse) Start = 1'b1;
    step();
    Start = 1'b0;
    check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
    check_eq("busy_cycles", 32'(busy_cyc), 32'(exp_done));
    check_eq("done_one_cycle", 32'(Done), 32'd0);
    check_eq("busy_after_done", 32'(Busy), 32'd0);
    check_eq("write_count", 32'(n_writes), 32'(exp_wr));
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
    check_eq({tag, "_done"}, 32'(Done), 32'd0);
    check_eq({tag, "_we"}, 32'(MemWriteEn), 32'd0);
    check_eq({tag, "_addr"}, 32'(MemAddress), 32'd0);
    check_eq({tag, "_wdata"}, 32'(MemDataOut), 32'd0);
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b1;
    Start = 1'b0;
    SrcAddr = 8'h00;
    DstAddr = 8'h00;
    Len = 8'h00;
`ifdef MEM_COPY_FILL_EN
    FillEn = 1'b0;
    FillData = 8'h00;
`endif
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle_outputs("reset");
    Reset = 1'b0;
    step();

    // Basic copy with Start re-pulsed mid-transfer and during DONE.
    mem[16] = 8'hA1; mem[17] = 8'hA2; mem[18] = 8'hA3; mem[19] = 8'hA4;
    push_copy(8'd16, 8'd64, 4);
    run_copy(8'd16, 8'd64, 8'd4, 9, 4, 1'b1);
    check_eq("copy_m64", 32'(mem[64]), 32'hA1);
    check_eq("copy_m65", 32'(mem[65]), 32'hA2);
    check_eq("copy_m66", 32'(mem[66]), 32'hA3);
    check_eq("copy_m67", 32'(mem[67]), 32'hA4);
    check_eq("copy_ignored_repulse", 32'(mem[8'hF8]), 32'h00);

    // Zero length: DONE straight away, no write.
    run_copy(8'd5, 8'd6, 8'd0, 1, 0, 1'b0);
    check_eq("len0_m6", 32'(mem[6]), 32'h00);

    // Source wraps 255 -> 0.
    mem[254] = 8'h11; mem[255] = 8'h22; mem[0] = 8'h33;
    push_copy(8'd254, 8'd100, 3);
    run_copy(8'd254, 8'd100, 8'd3, 7, 3, 1'b0);
    check_eq("wrap_m100", 32'(mem[100]), 32'h11);
    check_eq("wrap_m101", 32'(mem[101]), 32'h22);
    check_eq("wrap_m102", 32'(mem[102]), 32'h33);

    // Overlap Dst = Src + 1 propagates the first byte.
    mem[32] = 8'h07; mem[33] = 8'h09; mem[34] = 8'h00;
    push_copy(8'd32, 8'd33, 2);
    run_copy(8'd32, 8'd33, 8'd2, 5, 2, 1'b0);
    check_eq("ovl_m33", 32'(mem[33]), 32'h07);
    check_eq("ovl_m34", 32'(mem[34]), 32'h07);

    // Reset after the second write: abort, no Done, no more writes.
    push_copy(8'd16, 8'd150, 2);
    n_writes = 0;
    SrcAddr = 8'd16;
    DstAddr = 8'd150;
    Len     = 8'd4;
    Start   = 1'b1;
    saw_done = 1'b0;
    for (int c = 1; c <= 20 && n_writes < 2; c++) begin
      step();
      Start = 1'b0;
    end
    check_eq("abort_reached_2", 32'(n_writes), 32'd2);
    Reset = 1'b1;
    step();
    check_idle_outputs("abort");
    Reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (Done === 1'b1) saw_done = 1'b1;
    end
    check_eq("abort_no_done", 32'(saw_done), 32'd0);
    check_eq("abort_writes", 32'(n_writes), 32'd2);
    check_eq("abort_m150", 32'(mem[150]), 32'hA1);
    check_eq("abort_m151", 32'(mem[151]), 32'hA2);
    check_eq("abort_m152", 32'(mem[152]), 32'h00);
    exp_q.delete();

`ifdef MEM_COPY_FILL_EN
    begin
      wr_t e;
      for (int i = 0; i < 3; i++) begin
        e.addr = 8'(200 + i);
        e.data = 8'h5A;
        exp_q.push_back(e);
      end
      FillEn   = 1'b1;
      FillData = 8'h5A;
      run_copy(8'd16, 8'd200, 8'd3, 4, 3, 1'b0);
      FillEn   = 1'b0;
      check_eq("fill_m200", 32'(mem[200]), 32'h5A);
      check_eq("fill_m202", 32'(mem[202]), 32'h5A);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
